// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and lane constants for the MEM-stage load/store unit.
package mips_lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } lsu_state_t;

  localparam logic [3:0] LANES_ALL     = 4'b1111;
  localparam logic [3:0] LANES_HALF_HI = 4'b1100;
  localparam logic [3:0] LANES_HALF_LO = 4'b0011;
  localparam logic [3:0] LANE_BYTE0    = 4'b1000;

  // The reserved size encoding behaves as a word access.
  function automatic mem_size_t decode_size(input logic [1:0] s);
    return (s == 2'b11) ? WORD : mem_size_t'(s);
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Pipeline-side and data-memory-side signals of the MEM-stage LSU.
interface mem_stage_lsu_if;

  logic        M_MemRead;
  logic        M_MemWrite;
  logic [1:0]  M_Size;
  logic        M_SignExtend;
  logic [31:0] M_Address;
  logic [31:0] M_WriteData;
  logic        M_Kill;
  logic        M_StallOther;
  logic [31:0] DataMem_In;
  logic        DataMem_Ready;
  logic        DataMem_Read;
  logic [3:0]  DataMem_Write;
  logic [29:0] DataMem_Address;
  logic [31:0] DataMem_Out;
  logic [31:0] M_ReadData;
  logic        M_Stall;
  logic        M_AddrErrLoad;
  logic        M_AddrErrStore;
  logic        M_BusErr;

  modport slave (
    input  M_MemRead, M_MemWrite, M_Size, M_SignExtend, M_Address, M_WriteData,
           M_Kill, M_StallOther, DataMem_In, DataMem_Ready,
    output DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out,
           M_ReadData, M_Stall, M_AddrErrLoad, M_AddrErrStore, M_BusErr
  );

  modport master (
    output M_MemRead, M_MemWrite, M_Size, M_SignExtend, M_Address, M_WriteData,
           M_Kill, M_StallOther, DataMem_In, DataMem_Ready,
    input  DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out,
           M_ReadData, M_Stall, M_AddrErrLoad, M_AddrErrStore, M_BusErr
  );

endinterface

// File: rtl/mem_stage_lsu_align.sv
// Big-endian lane steering: store byte enables/replication, load extract/extend, misalignment.
module mem_align
  import mips_lsu_pkg::*;
(
  input  mem_size_t   op_size_i,
  input  logic [1:0]  op_addr_i,
  input  logic [31:0] st_data_i,
  input  mem_size_t   ld_size_i,
  input  logic [1:0]  ld_addr_i,
  input  logic        ld_sext_i,
  input  logic [31:0] ld_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o,
  output logic        misalign_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be_o       = LANES_ALL;
    st_data_o  = st_data_i;
    misalign_o = 1'b0;
    case (op_size_i)
      BYTE: begin
        be_o      = LANE_BYTE0 >> op_addr_i;
        st_data_o = {4{st_data_i[7:0]}};
      end
      HALF: begin
        be_o       = op_addr_i[1] ? LANES_HALF_LO : LANES_HALF_HI;
        st_data_o  = {2{st_data_i[15:0]}};
        misalign_o = op_addr_i[0];
      end
      default: misalign_o = |op_addr_i;
    endcase
  end

  always_comb begin
    ld_byte = ld_data_i[31:24];
    case (ld_addr_i)
      2'd1:    ld_byte = ld_data_i[23:16];
      2'd2:    ld_byte = ld_data_i[15:8];
      2'd3:    ld_byte = ld_data_i[7:0];
      default: ld_byte = ld_data_i[31:24];
    endcase
    ld_half = ld_addr_i[1] ? ld_data_i[15:0] : ld_data_i[31:16];
    case (ld_size_i)
      BYTE:    ld_data_o = {{24{ld_sext_i & ld_byte[7]}}, ld_byte};
      HALF:    ld_data_o = {{16{ld_sext_i & ld_half[15]}}, ld_half};
      default: ld_data_o = ld_data_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage LSU: one handshaked data-memory transaction per instruction, with
// stall generation, kill discard and bus timeout.
module mem_stage_lsu
  import mips_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clock,
  input  logic           reset,
  mem_stage_lsu_if.slave bus
);

  lsu_state_t  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        kill_q, kill_d;
  logic        read_q, read_d;
  logic [3:0]  we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        berr_q, berr_d;
  mem_size_t   size_q, size_d;
  logic [1:0]  alo_q, alo_d;
  logic        sext_q, sext_d;
  logic        load_q, load_d;

  mem_size_t   op_size;
  logic [3:0]  be;
  logic [31:0] st_data, ld_data;
  logic        misalign, any_op, valid, kill_seen, timeout, stall;

  assign op_size   = decode_size(bus.M_Size);
  assign any_op    = bus.M_MemRead | bus.M_MemWrite;
  assign valid     = any_op & ~misalign & ~bus.M_Kill;
  assign kill_seen = kill_q | bus.M_Kill;
  assign timeout   = (TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd1) == TIMEOUT_CYCLES);

  // Load formatting uses the size/offset captured at issue, not the live inputs.
  mem_align u_align (
    .op_size_i  (op_size),
    .op_addr_i  (bus.M_Address[1:0]),
    .st_data_i  (bus.M_WriteData),
    .ld_size_i  (size_q),
    .ld_addr_i  (alo_q),
    .ld_sext_i  (sext_q),
    .ld_data_i  (bus.DataMem_In),
    .be_o       (be),
    .st_data_o  (st_data),
    .ld_data_o  (ld_data),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    read_d  = read_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    berr_d  = berr_q;
    size_d  = size_q;
    alo_d   = alo_q;
    sext_d  = sext_q;
    load_d  = load_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          stall   = 1'b1;
          state_d = ACCESS;
          cnt_d   = '0;
          kill_d  = 1'b0;
          read_d  = bus.M_MemRead;
          we_d    = bus.M_MemRead ? '0 : be;
          wdata_d = bus.M_MemRead ? '0 : st_data;
          addr_d  = bus.M_Address[31:2];
          size_d  = op_size;
          alo_d   = bus.M_Address[1:0];
          sext_d  = bus.M_SignExtend;
          load_d  = bus.M_MemRead;
        end
      end
      ACCESS: begin
        stall  = 1'b1;
        kill_d = kill_seen;
        if (bus.DataMem_Ready || timeout) begin
          read_d  = 1'b0;
          we_d    = '0;
          addr_d  = '0;
          wdata_d = '0;
          if (kill_seen) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            if (bus.DataMem_Ready) begin
              rdata_d = load_q ? ld_data : '0;
            end else begin
              rdata_d = '0;
              berr_d  = 1'b1;
            end
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE: begin
        if (!bus.M_StallOther) begin
          state_d = IDLE;
          berr_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      read_q  <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      berr_q  <= 1'b0;
      size_q  <= BYTE;
      alo_q   <= '0;
      sext_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      read_q  <= read_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
      size_q  <= size_d;
      alo_q   <= alo_d;
      sext_q  <= sext_d;
      load_q  <= load_d;
    end
  end

  assign bus.DataMem_Read    = read_q;
  assign bus.DataMem_Write   = we_q;
  assign bus.DataMem_Address = addr_q;
  assign bus.DataMem_Out     = wdata_q;
  assign bus.M_ReadData      = rdata_q;
  assign bus.M_BusErr        = berr_q;
  assign bus.M_Stall         = stall & ~reset;
  assign bus.M_AddrErrLoad   = (state_q == IDLE) & bus.M_MemRead & misalign;
  assign bus.M_AddrErrStore  = (state_q == IDLE) & bus.M_MemWrite & ~bus.M_MemRead & misalign;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit for the MIPS32 core: the producer side of the MEM->WB boundary, generating M_ReadData and M_Stall.
- Takes the MEM-stage memory operation and runs exactly one handshaked transaction per instruction on the data-memory port.
- Formats big-endian byte, half and word accesses, and stalls MEM until load data is valid.
- Flags misaligned addresses and bus timeouts for the exception logic.

Parameters:
- TIMEOUT_CYCLES, 255: ACCESS cycles without DataMem_Ready before a bus error is raised; 0 disables the timeout.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- M_MemRead  in  1  load in MEM.
- M_MemWrite  in  1  store in MEM.
- M_Size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- M_SignExtend  in  1  sign-extend byte/half loads.
- M_Address  in  32  byte address.
- M_WriteData  in  32  store data, right-justified.
- M_Kill  in  1  exception flush of the MEM instruction.
- M_StallOther  in  1  non-LSU stall holding the MEM instruction.
- DataMem_In  in  32  read data from memory.
- DataMem_Ready  in  1  memory completes the current request.
- DataMem_Read  out  1  read request, registered.
- DataMem_Write  out  4  byte write enables, registered; bit3 = bits 31:24.
- DataMem_Address  out  30  word address, registered.
- DataMem_Out  out  32  lane-replicated store data, registered.
- M_ReadData  out  32  formatted load data, registered.
- M_Stall  out  1  LSU stall to pipeline, combinational from state and inputs.
- M_AddrErrLoad  out  1  misaligned load, combinational.
- M_AddrErrStore  out  1  misaligned store, combinational.
- M_BusErr  out  1  timeout flag.

Behaviour:
- Reset: state IDLE; all registered outputs 0; M_Stall forced 0 while reset is high.
  - Reset mid-ACCESS drops the request immediately; no completion is reported.
- Valid op: (M_MemRead | M_MemWrite) & aligned & !M_Kill.
  - If both M_MemRead and M_MemWrite are high, perform the load only.
- Alignment:
  - Half is misaligned when Address[0]=1.
  - Word is misaligned when Address[1:0]!=0.
  - A misaligned op issues no request and no stall; the AddrErr flag is high while the op is presented in IDLE.
- IDLE:
  - Valid op -> M_Stall=1; register the request (Read, or byte enables plus data, plus Address[31:2]); go to ACCESS. Timeout counter=0.
  - Otherwise M_Stall=0.
- ACCESS:
  - M_Stall=1; request outputs held stable.
  - On DataMem_Ready: clear the request; capture formatted load data (0 for stores) into M_ReadData; go to DONE. If M_Kill was seen during the access, go to IDLE instead and leave M_ReadData unchanged.
  - If the counter reaches TIMEOUT_CYCLES: clear the request, set M_BusErr, set M_ReadData=0, go to DONE.
- DONE:
  - M_Stall=0; M_ReadData and M_BusErr held.
  - If M_StallOther=1, stay in DONE with no reissue.
  - Else go to IDLE and clear M_BusErr.
- Minimum load latency: 2 stall cycles (IDLE, then ACCESS with Ready=1); the instruction leaves MEM at the end of the DONE cycle.
- M_Kill arriving in ACCESS does not abort the bus cycle; the transaction completes (or times out) and is then discarded.
- Store lanes (big-endian):
  - Byte at a -> enable bit (3-a), data {4{wd[7:0]}}.
  - Half at 0 -> 1100; half at 2 -> 0011; data {2{wd[15:0]}}.
  - Word -> 1111.
- Load extract:
  - Byte a: bits [31-8a -: 8].
  - Half at 0: [31:16]; half at 2: [15:0].
  - Zero- or sign-extend per M_SignExtend.

Decomposition:
- Shared package mips_lsu_pkg: mem_size_t enum (BYTE, HALF, WORD); lsu_state_t enum (IDLE, ACCESS, DONE); lane constants.
- Sub-module mem_align (combinational) generates byte enables, replicated store data, load extraction/extension and misalign flags.
- mem_stage_lsu holds the FSM, timeout counter and output registers.

Test Plan:
- LB, Address=0x103, SignExtend=1, DataMem_In=0x11223380, Ready in the first ACCESS cycle -> 2 stall cycles, M_ReadData=0xFFFFFF80.
- SH, Address=0x202, WriteData=0x0000BEEF -> DataMem_Write=0011, DataMem_Out=0xBEEFBEEF, DataMem_Address=0x80; Ready after 3 cycles -> M_Stall high 4 cycles.
- LW, Address=0x6 -> M_AddrErrLoad=1, M_Stall=0, DataMem_Read never asserted.
- LW with Ready arriving while M_StallOther=1 for 3 further cycles -> one transaction only; DONE held; M_ReadData stable.
- TIMEOUT_CYCLES=4, Ready never asserted -> request drops after 4 ACCESS cycles; M_BusErr=1; M_ReadData=0; stall released.
- Reset asserted in ACCESS -> DataMem_Read=0 immediately (asynchronous); after release, state IDLE and all outputs 0.
